// File: rtl/blend_pkg.sv
// Shared defaults, reset thresholds and the pixel clamp used by the blend scheduler.
package blend_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int DW_DEF      = 8;

   localparam logic [DW_DEF-1:0] TH0_RST = '0;
   localparam logic [DW_DEF-1:0] TH1_RST = '1;

   typedef struct packed {
      logic              clamped;
      logic [DW_DEF-1:0] value;
   } clamp_res_t;

   // The low-threshold test wins, so an inverted pair still gives a defined result.
   function automatic clamp_res_t clamp_px(input logic [DW_DEF-1:0] a,
                                           input logic [DW_DEF-1:0] th0,
                                           input logic [DW_DEF-1:0] th1);
      clamp_res_t r;
      if (a < th0)      r.value = th0;
      else if (a > th1) r.value = th1;
      else              r.value = a;
      r.clamped = (r.value != a);
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps; the pointer lives in the caller.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDW-1:0]     idx
);

   logic found;

   // NOTE: every output of this block is given a default first, so no path leaves a latch behind.
   always_comb begin
      int j;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && req[j]) begin
            found = 1'b1;
            idx   = IDW'(j);
         end
      end
      if (en && found) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/blend_clamp_sched.sv
// Shares one threshold clamp among NUM_REQ requesters: round-robin grant, one registered
// output stage, and shadow/active thresholds committed at frame_start.
module blend_clamp_sched
   import blend_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DW      = DW_DEF,
   parameter int IDW     = $clog2(NUM_REQ),
   parameter int CW      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_wr,
   input  logic [DW-1:0]         cfg_th0,
   input  logic [DW-1:0]         cfg_th1,
   input  logic                  frame_start,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*DW-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DW-1:0]         out_data,
   output logic [IDW-1:0]        out_id,
   output logic                  out_clamped,
   output logic                  cfg_err,
   output logic [CW-1:0]         clamp_cnt
);

   logic [DW-1:0]      sh_th0, sh_th1, act_th0, act_th1;
   logic [DW-1:0]      new_th0, new_th1;
   logic [IDW-1:0]     ptr, gnt_idx;
   logic [NUM_REQ-1:0] gnt;
   logic               load_en, accept;
   logic [DW-1:0]      sel_px;
   clamp_res_t         res;

   assign load_en = !out_valid || out_ready;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
      .req (req_valid),
      .ptr (ptr),
      .en  (load_en),
      .gnt (gnt),
      .idx (gnt_idx)
   );

   assign req_ready = gnt;
   assign accept    = |gnt;
   assign sel_px    = req_data[gnt_idx*DW +: DW];
   assign res       = clamp_px(sel_px, act_th0, act_th1);

   // A write landing in the commit cycle bypasses the shadow straight into active.
   assign new_th0 = cfg_wr ? cfg_th0 : sh_th0;
   assign new_th1 = cfg_wr ? cfg_th1 : sh_th1;

   // NOTE: reset is tested inside the clocked block (synchronous) and all state uses <=.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_th0      <= TH0_RST;
         sh_th1      <= TH1_RST;
         act_th0     <= TH0_RST;
         act_th1     <= TH1_RST;
         cfg_err     <= 1'b0;
         ptr         <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_id      <= '0;
         out_clamped <= 1'b0;
         clamp_cnt   <= '0;
      end else begin
         if (cfg_wr) begin
            sh_th0 <= cfg_th0;
            sh_th1 <= cfg_th1;
         end
         if (frame_start) begin
            act_th0 <= new_th0;
            act_th1 <= new_th1;
            cfg_err <= (new_th0 > new_th1);
         end
         if (load_en) begin
            out_valid <= accept;
            if (accept) begin
               out_data    <= res.value;
               out_id      <= gnt_idx;
               out_clamped <= res.clamped;
               ptr         <= (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            end
         end
         if (frame_start)
            clamp_cnt <= '0;
         else if (out_valid && out_ready && out_clamped && (clamp_cnt != '1))
            clamp_cnt <= clamp_cnt + 1'b1;
      end
   end

endmodule
